// File: rtl/serial_adder_ctrl.sv
// serial_adder_ctrl: bit-serial LSB-first adder with valid/ready handshakes (optional SERIAL_ADD_SUB_EN adds subtract mode)
module serial_adder_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
`ifdef SERIAL_ADD_SUB_EN
    input  logic             sub,
`endif
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             carry_out,
    output logic             busy
);
    localparam int CNT_W = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   a_q, a_d, b_q, b_d, r_q, r_d, sum_q, sum_d;
    logic               c_q, c_d, cout_q, cout_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               p, s, g, sub_w;
    logic [WIDTH:0]     r_ext;

`ifdef SERIAL_ADD_SUB_EN
    assign sub_w = sub;
`else
    assign sub_w = 1'b0;
`endif

    assign in_ready  = state_q == IDLE;
    assign out_valid = state_q == DONE;
    assign busy      = state_q != IDLE;
    assign sum       = sum_q;
    assign carry_out = cout_q;

    // Next state: operand load on accept, one full-adder step per RUN cycle, result latch on the last bit
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        r_d     = r_q;
        c_d     = c_q;
        cnt_d   = cnt_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        p       = a_q[0] ^ b_q[0];
        s       = p ^ c_q;
        g       = a_q[0] & b_q[0];
        r_ext   = {s, r_q};
        case (state_q)
            IDLE: if (in_valid) begin
                a_d     = op_a;
                b_d     = sub_w ? ~op_b : op_b;
                c_d     = sub_w;
                cnt_d   = '0;
                state_d = RUN;
            end
            RUN: begin
                c_d   = g | (p & c_q);
                r_d   = r_ext[WIDTH:1];
                a_d   = a_q >> 1;
                b_d   = b_q >> 1;
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(WIDTH - 1)) begin
                    sum_d   = r_ext[WIDTH:1];
                    cout_d  = g | (p & c_q);
                    state_d = DONE;
                end
            end
            DONE: if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers with synchronous active-low clear
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            r_q     <= '0;
            c_q     <= 1'b0;
            cnt_q   <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            r_q     <= r_d;
            c_q     <= c_d;
            cnt_q   <= cnt_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
        end
    end
endmodule

// File: tb/tb_serial_adder_ctrl.sv
// tb_serial_adder_ctrl: directed self-checking bench for serial_adder_ctrl (WIDTH=8 and WIDTH=1 instances)
module tb_serial_adder_ctrl;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0, out_ready = 1'b0, sub = 1'b0;
    logic [7:0] op_a = '0, op_b = '0;
    logic       in_ready, out_valid, carry_out, busy;
    logic [7:0] sum;
    logic       in_valid1 = 1'b0, out_ready1 = 1'b0;
    logic [0:0] op_a1 = '0, op_b1 = '0, sum1;
    logic       in_ready1, out_valid1, carry_out1, busy1;
    int         n_chk = 0, n_fail = 0;
    int         lat;
    logic       flag;

    always #5 clk = ~clk;

    serial_adder_ctrl #(.WIDTH(8)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
`ifdef SERIAL_ADD_SUB_EN
        .sub(sub),
`endif
        .op_a(op_a), .op_b(op_b), .out_valid(out_valid), .out_ready(out_ready),
        .sum(sum), .carry_out(carry_out), .busy(busy)
    );

    serial_adder_ctrl #(.WIDTH(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid1), .in_ready(in_ready1),
`ifdef SERIAL_ADD_SUB_EN
        .sub(1'b0),
`endif
        .op_a(op_a1), .op_b(op_b1), .out_valid(out_valid1), .out_ready(out_ready1),
        .sum(sum1), .carry_out(carry_out1), .busy(busy1)
    );

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Accept one operation, optionally poke in_valid mid-RUN, and stop at the first DONE cycle
    task automatic run_op(input string tag, input logic [7:0] a, input logic [7:0] b,
                          input logic sb, input logic poke);
        op_a = a; op_b = b; sub = sb; in_valid = 1'b1;
        tick();
        in_valid = 1'b0; op_a = 8'h11; op_b = 8'h22; sub = 1'b0;
        chk({tag, "_busy"}, busy, 1);
        chk({tag, "_in_ready_run"}, in_ready, 0);
        lat = 0;
        while (!out_valid && lat < 40) begin
            in_valid = poke && lat == 3;
            tick();
            lat++;
        end
        in_valid = 1'b0;
        chk({tag, "_latency"}, lat, 8);
    endtask

    initial begin
        rst_n = 1'b0;
        tick(); tick();
        rst_n = 1'b1;
        tick();
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_sum", sum, 8'h00);
        chk("rst_cout", carry_out, 0);

        out_ready = 1'b1;
        run_op("add5a3c", 8'h5A, 8'h3C, 1'b0, 1'b0);
        chk("add5a3c_sum", sum, 8'h96);
        chk("add5a3c_cout", carry_out, 0);
        chk("add5a3c_in_ready_done", in_ready, 0);
        tick();
        chk("add5a3c_in_ready_after", in_ready, 1);
        chk("add5a3c_out_valid_after", out_valid, 0);
        chk("add5a3c_sum_kept", sum, 8'h96);

        run_op("ovf", 8'hFF, 8'h01, 1'b0, 1'b1);
        chk("ovf_sum", sum, 8'h00);
        chk("ovf_cout", carry_out, 1);
        tick();
        flag = 1'b0;
        for (int i = 0; i < 12; i++) begin
            flag |= out_valid | busy | !in_ready;
            tick();
        end
        chk("ovf_single_result", flag, 0);

        out_ready = 1'b0;
        run_op("bp", 8'h80, 8'h80, 1'b0, 1'b0);
        flag = 1'b0;
        for (int i = 0; i < 5; i++) begin
            flag |= sum !== 8'h00 || carry_out !== 1'b1 || in_ready !== 1'b0 || out_valid !== 1'b1;
            tick();
        end
        chk("bp_hold", flag, 0);
        chk("bp_sum", sum, 8'h00);
        chk("bp_cout", carry_out, 1);
        out_ready = 1'b1;
        tick();
        chk("bp_release_in_ready", in_ready, 1);

        op_a = 8'h77; op_b = 8'h11; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick(); tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk("abort_in_ready", in_ready, 1);
        chk("abort_busy", busy, 0);
        chk("abort_sum", sum, 8'h00);
        flag = 1'b0;
        for (int i = 0; i < 12; i++) begin
            flag |= out_valid;
            tick();
        end
        chk("abort_no_valid", flag, 0);
        run_op("post_abort", 8'h01, 8'h02, 1'b0, 1'b0);
        chk("post_abort_sum", sum, 8'h03);
        chk("post_abort_cout", carry_out, 0);
        tick();

`ifdef SERIAL_ADD_SUB_EN
        run_op("sub10", 8'h10, 8'h01, 1'b1, 1'b0);
        chk("sub10_sum", sum, 8'h0F);
        chk("sub10_cout", carry_out, 1);
        tick();
        run_op("sub00", 8'h00, 8'h01, 1'b1, 1'b0);
        chk("sub00_sum", sum, 8'hFF);
        chk("sub00_cout", carry_out, 0);
        tick();
        run_op("sub_off", 8'h10, 8'h01, 1'b0, 1'b0);
        chk("sub_off_sum", sum, 8'h11);
        tick();
`endif

        out_ready1 = 1'b1;
        op_a1 = 1'b1; op_b1 = 1'b1; in_valid1 = 1'b1;
        tick();
        in_valid1 = 1'b0;
        chk("w1_run_valid", out_valid1, 0);
        tick();
        chk("w1_valid", out_valid1, 1);
        chk("w1_sum", sum1, 0);
        chk("w1_cout", carry_out1, 1);
        tick();
        op_a1 = 1'b1; op_b1 = 1'b0; in_valid1 = 1'b1;
        tick();
        in_valid1 = 1'b0;
        tick();
        chk("w1b_valid", out_valid1, 1);
        chk("w1b_sum", sum1, 1);
        chk("w1b_cout", carry_out1, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/serial_adder_ctrl.md
Name: serial_adder_ctrl

Overview:
- Sequencer that performs a WIDTH-bit addition bit-serially, LSB first, one bit per clock.
- Datapath per bit is a full adder built from two half-adder stages (XOR/AND) plus an OR for carry, with a registered carry between bits.
- Block owns the operand/result shift registers, bit counter and FSM, and presents valid/ready handshakes on both sides.
- Trades latency for area where one shared 1-bit adder replaces a WIDTH-bit ripple adder.

Parameters:
- WIDTH, 8, operand and result width in bits; legal range 1..32.
- CNT_W, $clog2(WIDTH)+1, bit-counter width; derived, not overridden.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  synchronous active-low reset
- in_valid  input  1  operands presented
- in_ready  output  1  block can accept operands (high only in IDLE)
- op_a  input  WIDTH  operand A, sampled on accept
- op_b  input  WIDTH  operand B, sampled on accept
- out_valid  output  1  result available (high only in DONE)
- out_ready  input  1  consumer takes result
- sum  output  WIDTH  result
- carry_out  output  1  final carry
- busy  output  1  high in RUN or DONE

Behaviour:
- Reset: sampled on a clk edge with rst_n=0.
  - state=IDLE; shift registers, carry, counter, sum and carry_out all cleared.
  - Resulting outputs: in_ready=1, out_valid=0, busy=0, sum=0, carry_out=0.
  - Reset during RUN or DONE aborts the operation. The result is discarded and out_valid is never raised for it.
- FSM states IDLE, RUN, DONE. in_ready, out_valid and busy are decoded from state only, with no combinational path from inputs.
- IDLE:
  - On in_valid & in_ready at an edge (accept): load A_sr=op_a, B_sr=op_b, carry=0, cnt=0, then go to RUN.
  - in_valid=0 keeps the block in IDLE.
- RUN, every edge:
  - p = A_sr[0]^B_sr[0]; s = p^carry; carry <= (A_sr[0]&B_sr[0]) | (p&carry).
  - R_sr <= {s, R_sr[WIDTH-1:1]}; A_sr and B_sr shift right by one; cnt <= cnt+1.
  - On the edge where cnt==WIDTH-1: sum <= final shifted R_sr, carry_out <= final carry, go to DONE.
- Latency: out_valid rises exactly WIDTH edges after the accepting edge (WIDTH=8 gives 8 cycles).
- DONE:
  - out_valid=1. sum and carry_out stay stable while out_ready=0, with no limit on backpressure.
  - On out_ready=1 at an edge, go to IDLE. in_ready returns on the next cycle; no same-cycle turnaround.
- in_valid asserted during RUN or DONE is ignored. op_a and op_b are never resampled mid-operation.
- sum and carry_out keep their last value in IDLE. They are meaningful only when out_valid=1.
- Arithmetic is modulo 2^WIDTH. carry_out is bit WIDTH of the true sum.
- WIDTH=1: RUN lasts one cycle, and the result is a plain full-adder output with carry-in 0.

Optional Feature:
- Macro: SERIAL_ADD_SUB_EN.
- Defined:
  - Adds input port sub (1 bit), sampled on accept.
  - When sub=1: B_sr loads ~op_b, carry initialises to 1, so sum = op_a - op_b mod 2^WIDTH.
  - In subtract mode, carry_out=1 means no borrow (op_a >= op_b unsigned).
  - sub=0 gives identical behaviour to the add-only build.
- Undefined: port sub is absent and the block is add-only with carry init 0.

Test Plan:
- Reset: hold rst_n=0 for 2 edges, release -> in_ready=1, out_valid=0, busy=0, sum=8'h00, carry_out=0.
- Add with handshake timing: WIDTH=8, accept op_a=8'h5A, op_b=8'h3C, out_ready=1 ->
  - out_valid rises 8 cycles after accept with sum=8'h96, carry_out=0.
  - in_ready is high the cycle after DONE.
- Overflow plus ignored input: op_a=8'hFF, op_b=8'h01 -> sum=8'h00, carry_out=1. A second in_valid pulse during RUN is ignored, so only one result is produced.
- Backpressure: op_a=8'h80, op_b=8'h80, out_ready=0 for 5 cycles after out_valid -> sum=8'h00, carry_out=1 held stable, in_ready=0 throughout. out_ready=1 returns the block to IDLE.
- Reset mid-operation: rst_n=0 on the 3rd RUN cycle -> next cycle IDLE, out_valid never asserted, sum=0. A following accept of 8'h01+8'h02 gives 8'h03.
- With SERIAL_ADD_SUB_EN:
  - sub=1, 8'h10-8'h01 -> sum=8'h0F, carry_out=1.
  - sub=1, 8'h00-8'h01 -> sum=8'hFF, carry_out=0.
  - Also run a WIDTH=1 build: 1+1 -> sum=0, carry_out=1 after 1 cycle.
